// File: rtl/rib_rr_arbiter_pkg.sv
// Shared widths, constants and grant payload type for the RIB round-robin arbiter.
package rib_rr_arbiter_pkg;

   localparam int unsigned RIB_MASTER_NUM = 4;
   localparam int unsigned RIB_GRANT_W    = 2;
   localparam int unsigned CNT_W          = 8;

   localparam logic [CNT_W-1:0] CNT_SAT   = 8'hFF;

   localparam logic HOLD_ENABLE  = 1'b1;
   localparam logic HOLD_DISABLE = 1'b0;

   // Arbiter FSM encoding
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Grant payload handed to the crossbar mux
   typedef struct packed {
      logic                   vld;
      logic [RIB_GRANT_W-1:0] idx;
   } rib_grant_t;

endpackage

// File: rtl/rib_rr_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request after ptr, wrapping, ptr last.
module rr_pick4
   import rib_rr_arbiter_pkg::*;
(
   input  logic [RIB_MASTER_NUM-1:0] req,
   input  logic [RIB_GRANT_W-1:0]    ptr,
   output logic [RIB_GRANT_W-1:0]    idx,
   output logic                      any
);

   logic [RIB_GRANT_W-1:0] cand;

   // Scan farthest offset first so the nearest requester after ptr wins
   always_comb begin
      idx  = ptr;
      any  = |req;
      cand = '0;
      for (int k = RIB_MASTER_NUM; k >= 1; k--) begin
         cand = ptr + RIB_GRANT_W'(k);
         if (req[cand]) begin
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/rib_rr_arbiter.sv
// Registered round-robin arbiter for the four RIB masters with lock and burst limit.
module rib_rr_arbiter
   import rib_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned FETCH_M   = 1
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [RIB_MASTER_NUM-1:0] req_i,
   input  logic [RIB_MASTER_NUM-1:0] lock_i,
   output logic [RIB_GRANT_W-1:0]    grant_o,
   output logic                      grant_vld_o,
   output logic [RIB_MASTER_NUM-1:0] grant_oh_o,
   output logic                      hold_flag_o,
   output logic [CNT_W-1:0]          burst_cnt_o
);

   localparam logic [CNT_W-1:0]          BURST_LIM  = CNT_W'(MAX_BURST);
   localparam logic [RIB_GRANT_W-1:0]    FETCH_IDX  = RIB_GRANT_W'(FETCH_M);
   localparam logic [RIB_MASTER_NUM-1:0] FETCH_MASK = 4'b0001 << FETCH_IDX;
   localparam logic [RIB_GRANT_W-1:0]    PTR_RST    = 2'd3;

   logic [0:0]                state_q, state_d;
   rib_grant_t                grant_q, grant_d;
   logic [RIB_MASTER_NUM-1:0] oh_q, oh_d;
   logic [RIB_GRANT_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   logic [RIB_GRANT_W-1:0]    pick_idx;
   logic                      pick_any;
   logic [RIB_MASTER_NUM-1:0] owner_mask;
   logic                      own_req;
   logic                      own_lock;
   logic                      others_req;

   rr_pick4 u_pick (
      .req (req_i),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Owner view of the current request/lock vectors
   always_comb begin
      owner_mask = 4'b0001 << grant_q.idx;
      own_req    = req_i[grant_q.idx];
      own_lock   = lock_i[grant_q.idx];
      others_req = |(req_i & ~owner_mask);
   end

   // Next-state: grant, keep, lock hold, rotation or release to idle
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               grant_d.vld = 1'b1;
               grant_d.idx = pick_idx;
               ptr_d       = pick_idx;
               cnt_d       = CNT_W'(1);
               state_d     = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (own_req && (own_lock || (cnt_q < BURST_LIM) || !others_req)) begin
               cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            end else if (!own_req && own_lock) begin
               // Locked owner idles on the bus; ownership and count frozen
               cnt_d = cnt_q;
            end else if (pick_any) begin
               // ptr equals the owner here, so the owner is searched last
               grant_d.idx = pick_idx;
               ptr_d       = pick_idx;
               cnt_d       = CNT_W'(1);
            end else begin
               grant_d.vld = 1'b0;
               cnt_d       = '0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            grant_d.vld = 1'b0;
         end
      endcase
      oh_d = grant_d.vld ? (4'b0001 << grant_d.idx) : '0;
   end

   // State and output registers, async active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         grant_q.vld <= 1'b0;
         grant_q.idx <= FETCH_IDX;
         oh_q        <= '0;
         ptr_q       <= PTR_RST;
         cnt_q       <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         oh_q    <= oh_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pipeline hold: any non-fetch requester, or a non-fetch owner
   always_comb begin
      hold_flag_o = ((|(req_i & ~FETCH_MASK)) || (grant_q.vld && (grant_q.idx != FETCH_IDX)))
                    ? HOLD_ENABLE : HOLD_DISABLE;
   end

   assign grant_o     = grant_q.idx;
   assign grant_vld_o = grant_q.vld;
   assign grant_oh_o  = oh_q;
   assign burst_cnt_o = cnt_q;

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed bench for rib_rr_arbiter: vector table plus multi-cycle corner sequences.
module tb_rib_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req, lock;
   logic [1:0] grant;
   logic       vld;
   logic [3:0] oh;
   logic       hold;
   logic [7:0] cnt;

   logic [3:0] req1, lock1;
   logic [1:0] grant1;
   logic       vld1;
   logic [3:0] oh1;
   logic       hold1;
   logic [7:0] cnt1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] lock;
      logic [1:0] grant;
      logic       vld;
      logic [3:0] oh;
      logic       hold;
      logic [7:0] cnt;
      logic       chk_cnt;
   } vec_t;

   vec_t vecs[17];

   rib_rr_arbiter #(.MAX_BURST(8), .FETCH_M(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req),
      .lock_i      (lock),
      .grant_o     (grant),
      .grant_vld_o (vld),
      .grant_oh_o  (oh),
      .hold_flag_o (hold),
      .burst_cnt_o (cnt)
   );

   rib_rr_arbiter #(.MAX_BURST(1), .FETCH_M(1)) dut_mb1 (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req1),
      .lock_i      (lock1),
      .grant_o     (grant1),
      .grant_vld_o (vld1),
      .grant_oh_o  (oh1),
      .hold_flag_o (hold1),
      .burst_cnt_o (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      rst = 1'b1;
   endtask

   initial begin
      int mx;
      int ec;
      rst   = 1'b0;
      req   = '0;
      lock  = '0;
      req1  = '0;
      lock1 = '0;

      //           req      lock     grant vld  oh       hold cnt  chk_cnt
      vecs[0]  = '{4'b0101, 4'b0000, 2'd0, 1'b1, 4'b0001, 1'b1, 8'd1, 1'b1};
      vecs[1]  = '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd1, 1'b1};
      vecs[2]  = '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b1};
      vecs[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0};
      vecs[4]  = '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b0, 8'd1, 1'b1};
      vecs[5]  = '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b0, 8'd2, 1'b1};
      vecs[6]  = '{4'b0110, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd3, 1'b1};
      vecs[7]  = '{4'b0110, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd4, 1'b1};
      vecs[8]  = '{4'b0110, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd5, 1'b1};
      vecs[9]  = '{4'b0110, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd6, 1'b1};
      vecs[10] = '{4'b0110, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd7, 1'b1};
      vecs[11] = '{4'b0110, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b1, 8'd8, 1'b1};
      vecs[12] = '{4'b0110, 4'b0000, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd1, 1'b1};
      vecs[13] = '{4'b0110, 4'b0010, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b1};
      vecs[14] = '{4'b0010, 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b1, 8'd2, 1'b1};
      vecs[15] = '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 1'b0, 8'd1, 1'b1};
      vecs[16] = '{4'b0000, 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0, 8'd0, 1'b0};

      // Reset state
      step();
      chk("rst grant", 32'(grant), 32'd1);
      chk("rst vld",   32'(vld),   32'd0);
      chk("rst oh",    32'(oh),    32'd0);
      chk("rst cnt",   32'(cnt),   32'd0);
      chk("rst hold",  32'(hold),  32'd0);
      rst = 1'b1;

      // Vector table
      for (int i = 0; i < 17; i++) begin
         req  = vecs[i].req;
         lock = vecs[i].lock;
         step();
         chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
         chk($sformatf("v%0d vld", i),   32'(vld),   32'(vecs[i].vld));
         chk($sformatf("v%0d oh", i),    32'(oh),    32'(vecs[i].oh));
         chk($sformatf("v%0d hold", i),  32'(hold),  32'(vecs[i].hold));
         if (vecs[i].chk_cnt) begin
            chk($sformatf("v%0d cnt", i), 32'(cnt), 32'(vecs[i].cnt));
         end
      end

      // All four request: strict rotation, 8 cycles each
      do_reset();
      req = 4'b1111;
      mx  = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         chk($sformatf("rot%0d grant", k), 32'(grant), 32'((k / 8) % 4));
         chk($sformatf("rot%0d cnt", k),   32'(cnt),   32'((k % 8) + 1));
         if (int'(cnt) > mx) mx = int'(cnt);
      end
      chk("rot peak cnt", 32'(mx), 32'd8);
      req = '0;

      // Lone requester keeps bus past MAX_BURST; counter saturates
      do_reset();
      req = 4'b0001;
      for (int k = 1; k <= 260; k++) begin
         step();
         ec = (k > 255) ? 255 : k;
         chk($sformatf("sat%0d grant", k), 32'(grant), 32'd0);
         chk($sformatf("sat%0d cnt", k),   32'(cnt),   32'(ec));
      end
      req = '0;

      // Locked master 3 holds through contention, then rotates to 0
      do_reset();
      req = 4'b1000;
      step();
      chk("lk start grant", 32'(grant), 32'd3);
      chk("lk start cnt",   32'(cnt),   32'd1);
      lock = 4'b1000;
      req  = 4'b1111;
      for (int k = 2; k <= 20; k++) begin
         step();
         chk($sformatf("lk%0d grant", k), 32'(grant), 32'd3);
      end
      chk("lk cnt 20", 32'(cnt), 32'd20);
      lock = '0;
      step();
      chk("lk release grant", 32'(grant), 32'd0);
      chk("lk release cnt",   32'(cnt),   32'd1);
      req = '0;
      step();

      // Reset asserted mid-grant clears outputs without a clock edge
      do_reset();
      req = 4'b0100;
      step();
      chk("mr pre grant", 32'(grant), 32'd2);
      chk("mr pre vld",   32'(vld),   32'd1);
      #3;
      rst = 1'b0;
      #1;
      chk("mr grant", 32'(grant), 32'd1);
      chk("mr vld",   32'(vld),   32'd0);
      chk("mr oh",    32'(oh),    32'd0);
      chk("mr cnt",   32'(cnt),   32'd0);
      chk("mr hold",  32'(hold),  32'd1);
      step();
      rst = 1'b1;
      chk("mr held vld", 32'(vld), 32'd0);
      step();
      chk("mr post grant", 32'(grant), 32'd2);
      chk("mr post vld",   32'(vld),   32'd1);
      chk("mr post oh",    32'(oh),    32'd4);
      req = '0;

      // MAX_BURST=1 instance rotates every cycle under contention
      do_reset();
      req1 = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         chk($sformatf("mb1_%0d grant", k), 32'(grant1), 32'(k % 4));
         chk($sformatf("mb1_%0d vld", k),   32'(vld1),   32'd1);
         chk($sformatf("mb1_%0d oh", k),    32'(oh1),    32'(4'b0001 << (k % 4)));
         chk($sformatf("mb1_%0d cnt", k),   32'(cnt1),   32'd1);
         chk($sformatf("mb1_%0d hold", k),  32'(hold1),  32'd1);
      end
      req1 = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
